// File: rtl/pool_window_feeder.sv
// pool_window_feeder: walks a feature map in 2x2 stride-2 windows, hands each
// window to the pooling unit and writes the pooled pixel back as a row-major map.
module pool_window_feeder #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [ADDR_W-1:0] base_in_addr,
    input  logic [ADDR_W-1:0] base_out_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] win_00,
    output logic [DATA_W-1:0] win_01,
    output logic [DATA_W-1:0] win_10,
    output logic [DATA_W-1:0] win_11,
    output logic              pool_start,
    input  logic              pool_finish,
    input  logic [DATA_W-1:0] pool_pixel,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW     = $clog2(IMG_W + 1);
    localparam int unsigned RW     = $clog2(IMG_H + 1);
    localparam int unsigned C_LAST = IMG_W - 2;
    localparam int unsigned R_LAST = IMG_H - 2;
    localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STRIDE2 = ADDR_W'(2 * IMG_W);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_CAP,
        S_START,
        S_WAIT,
        S_WRITE,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    // Address of pixel (row_q, 0); advanced by two map rows per window row.
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    // Address of the next pooled output pixel.
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic              rd_en_d, wr_en_d, start_d, busy_d, done_d;
    logic [ADDR_W-1:0] rd_addr_d, wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;
    logic [DATA_W-1:0] win_00_d, win_01_d, win_10_d, win_11_d;
    logic              col_wrap, row_wrap;

    // Address of a window pixel relative to the current row base and column.
    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [ADDR_W-1:0] row_base,
        input logic [CW-1:0]     col,
        input logic              dy,
        input logic              dx
    );
        logic [ADDR_W-1:0] row_off;
        row_off  = dy ? ROW_STRIDE : '0;
        pix_addr = row_base + row_off + ADDR_W'(col) + ADDR_W'(dx);
    endfunction

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        wr_ptr_d   = wr_ptr_q;
        rd_addr_d  = mem_rd_addr;
        wr_addr_d  = mem_wr_addr;
        wr_data_d  = mem_wr_data;
        win_00_d   = win_00;
        win_01_d   = win_01;
        win_10_d   = win_10;
        win_11_d   = win_11;
        col_wrap   = (32'(col_q) + 32'd2) > C_LAST;
        row_wrap   = (32'(row_q) + 32'd2) > R_LAST;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d    = S_RD0;
                    row_d      = '0;
                    col_d      = '0;
                    row_base_d = base_in_addr;
                    wr_ptr_d   = base_out_addr;
                    rd_addr_d  = base_in_addr;
                end
            end
            S_RD0: begin
                state_d   = S_RD1;
                rd_addr_d = pix_addr(row_base_q, col_q, 1'b0, 1'b1);
            end
            S_RD1: begin
                state_d   = S_RD2;
                win_00_d  = mem_rd_data;
                rd_addr_d = pix_addr(row_base_q, col_q, 1'b1, 1'b0);
            end
            S_RD2: begin
                state_d   = S_RD3;
                win_01_d  = mem_rd_data;
                rd_addr_d = pix_addr(row_base_q, col_q, 1'b1, 1'b1);
            end
            S_RD3: begin
                state_d  = S_CAP;
                win_10_d = mem_rd_data;
            end
            S_CAP: begin
                state_d  = S_START;
                win_11_d = mem_rd_data;
            end
            S_START: begin
                // finish during START is ignored: the result belongs to WAIT
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pool_finish) begin
                    state_d   = S_WRITE;
                    wr_data_d = pool_pixel;
                    wr_addr_d = wr_ptr_q;
                end
            end
            S_WRITE: begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                if (col_wrap) begin
                    col_d      = '0;
                    row_d      = row_q + RW'(2);
                    row_base_d = row_base_q + ROW_STRIDE2;
                    state_d    = row_wrap ? S_FIN : S_RD0;
                end else begin
                    col_d   = col_q + CW'(2);
                    state_d = S_RD0;
                end
                if (state_d == S_RD0) begin
                    rd_addr_d = pix_addr(row_base_d, col_d, 1'b0, 1'b0);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d = (state_d == S_RD0) || (state_d == S_RD1) ||
                  (state_d == S_RD2) || (state_d == S_RD3);
        wr_en_d = (state_d == S_WRITE);
        start_d = (state_d == S_START);
        done_d  = (state_d == S_FIN);
        busy_d  = (state_d != S_IDLE) && (state_d != S_FIN);
    end

    // State, counters and output registers; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            row_base_q  <= '0;
            wr_ptr_q    <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            win_00      <= '0;
            win_01      <= '0;
            win_10      <= '0;
            win_11      <= '0;
            pool_start  <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            row_base_q  <= row_base_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_rd_en   <= rd_en_d;
            mem_rd_addr <= rd_addr_d;
            win_00      <= win_00_d;
            win_01      <= win_01_d;
            win_10      <= win_10_d;
            win_11      <= win_11_d;
            pool_start  <= start_d;
            mem_wr_en   <= wr_en_d;
            mem_wr_addr <= wr_addr_d;
            mem_wr_data <= wr_data_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: doc/pool_window_feeder.md
Name: pool_window_feeder

Overview:
Sequencer on the initiator side of the 2x2 pooling unit's interface. It reads a feature map from a word-addressed memory in row-major order and builds non-overlapping 2x2 windows (stride 2). For each window it pulses the pooling unit's start and captures the pooled pixel when finish is returned. It writes each result back to memory as a row-major pooled map and sits between the feature-map buffer and the pooling datapath.

Parameters:
DATA_W, 16, pixel width.
ADDR_W, 16, memory address width.
IMG_W, 28, input map width in pixels; must be >= 2.
IMG_H, 28, input map height in pixels; must be >= 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
go  in  1  one-cycle request to process one map; sampled only in IDLE.
base_in_addr  in  ADDR_W  address of input pixel (0,0); sampled on the accepted go.
base_out_addr  in  ADDR_W  address of output pixel (0,0); sampled on the accepted go.
mem_rd_en  out  1  read strobe.
mem_rd_addr  out  ADDR_W  read address.
mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
win_00, win_01, win_10, win_11  out  DATA_W each  registered window pixels: top-left, top-right, bottom-left, bottom-right.
pool_start  out  1  one-cycle window-valid pulse to the pooling unit.
pool_finish  in  1  pooling result valid.
pool_pixel  in  DATA_W  pooled result.
mem_wr_en  out  1  write strobe.
mem_wr_addr  out  ADDR_W  write address.
mem_wr_data  out  DATA_W  write data.
busy  out  1  high from the cycle after an accepted go until done.
done  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset values: every output is 0, state is IDLE, row and column counters are 0.
- Output map size: OW = IMG_W/2, OH = IMG_H/2, both floor. An odd last column or row is never read.
- Window (r,c), with r and c even: read order (r,c), (r,c+1), (r+1,c), (r+1,c+1).
- Read address = base_in + y*IMG_W + x, computed modulo 2^ADDR_W.
- Write address = base_out + (r/2)*OW + c/2, computed modulo 2^ADDR_W.
- States:
  - IDLE: on go, latch the base addresses, clear counters, go to RD0.
  - RD0..RD3: assert mem_rd_en with the addresses in read order. Data returned during RD1..RD3 and CAP fills win_00, win_01, win_10, win_11 in turn.
  - CAP: capture the last pixel, then go to START.
  - START: pool_start = 1 for exactly this cycle; window registers are stable from START through WAIT.
  - WAIT: pool_start = 0. On the first cycle with pool_finish = 1, latch pool_pixel into mem_wr_data and go to WRITE. pool_finish sampled during START is ignored.
  - WRITE: mem_wr_en = 1 for one cycle. Advance c by 2. If c+2 > IMG_W-2, set c = 0 and advance r by 2. If r also passes IMG_H-2, go to FIN; otherwise go to RD0.
  - FIN: done = 1 for one cycle, busy = 0, then go to IDLE.
- Throughput: 8 cycles per window when pool_finish returns in the first WAIT cycle (RD0-3, CAP, START, WAIT, WRITE). WAIT has no timeout.
- go while busy: ignored, with no side effects.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- rst mid-operation: next cycle is IDLE, all outputs are 0, and the pending write is dropped.
- The feeder performs no arithmetic on pixels; pool_pixel is written as received.

Test Plan:
- IMG_W=IMG_H=4, base_in=0, base_out=0x40, mem[i]=4*i, behavioural pooling model (sum>>2, finish one cycle after start) -> writes 10@0x40, 18@0x41, 42@0x42, 50@0x43; done at cycle 33 after go; busy high for cycles 1-32.
- IMG_W=IMG_H=5, base_in=0x100, base_out=0x200 -> reads issued only to 0x100+{0,1,5,6}, then +{2,3,7,8}, +{10,11,15,16}, +{12,13,17,18}; exactly 4 writes to 0x200-0x203; column 4 and row 4 never read.
- Pooling model delays finish by 5 cycles -> pool_start is a single-cycle pulse; win_* stay constant through WAIT; the write occurs on the cycle after finish; each window takes 12 cycles.
- go pulsed again mid-run, and go held high for 3 cycles at start -> exactly one map is processed and exactly one done pulse is produced.
- rst asserted in the WAIT state of the 2nd window -> next cycle all outputs are 0; no write for window 2; a new go restarts from window (0,0) with the new base addresses.
- base_in=0xFFFE, IMG_W=IMG_H=2 -> read addresses are 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap-around); one write.
